board_game_core: RTL and testbench

- Parametrised N×N two-player placement-game engine: cursor movement, stone placement, turn tracking, K-in-a-row win detection and draw detection.
- Generalises the fixed 3×3 tic-tac-toe logic: configurable board size, win length and cursor wrap mode.
- Adds win/draw detection, restart, and a registered game-over state.
- Sits between the gamepad decoder (level button inputs) and the VGA renderer, which reads cells via a combinational read port.

---
 rtl/board_game_core.sv | 190 +++++++++++++++++++
 tb/tb_board_game_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_game_core.sv
// Two-player N x N placement-game engine: cursor, stone placement, turn tracking,
// K-in-a-row win search over four directions, draw detection and restart.
module board_game_core #(
   parameter int GRID_N  = 3,
   parameter int WIN_LEN = 3,
   parameter int WRAP    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_a,
   input  logic       btn_start,
   input  logic [2:0] rd_x,
   input  logic [2:0] rd_y,
   output logic [1:0] rd_cell,
   output logic [2:0] cursor_x,
   output logic [2:0] cursor_y,
   output logic       turn,
   output logic       busy,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [6:0] move_count
);

   localparam logic [2:0] MAX_C = 3'(GRID_N - 1);
   localparam logic [6:0] CELLS = 7'(GRID_N * GRID_N);

   typedef enum logic [1:0] {S_PLAY, S_CHECK, S_OVER} state_t;
   state_t state_q, state_d;

   logic [1:0] board_q [GRID_N][GRID_N];
   logic [5:0] btn_now, btn_q, press;   // {start, a, up, down, left, right}
   logic [2:0] px_q, py_q;
   logic       player_q, win_q;
   logic [1:0] dir_q;
   logic       do_restart, do_place, do_move, check_last, hit;
   logic [1:0] cur_cell, mark;
   int         run_len, dx, dy, xx, yy;
   logic       go;

   assign btn_now   = {btn_start, btn_a, btn_up, btn_down, btn_left, btn_right};
   assign press     = btn_now & ~btn_q;
   assign cur_cell  = board_q[cursor_y][cursor_x];
   assign busy      = (state_q == S_CHECK);
   assign game_over = (state_q == S_OVER);
   assign rd_cell   = (int'(rd_x) < GRID_N && int'(rd_y) < GRID_N) ? board_q[rd_y][rd_x] : 2'b00;

   // Same-player run through the placed cell along the direction of this CHECK cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves a latch.
      dx      = 1;
      dy      = 0;
      xx      = 0;
      yy      = 0;
      go      = 1'b0;
      run_len = 1;
      mark    = player_q ? 2'b10 : 2'b01;
      case (dir_q)
         2'd1:    begin dx = 0; dy = 1;  end
         2'd2:    begin dx = 1; dy = 1;  end
         2'd3:    begin dx = 1; dy = -1; end
         default: begin dx = 1; dy = 0;  end
      endcase
      for (int s = 0; s < 2; s++) begin
         go = 1'b1;
         for (int i = 1; i < WIN_LEN; i++) begin
            xx = int'(px_q) + ((s == 0) ? i : -i) * dx;
            yy = int'(py_q) + ((s == 0) ? i : -i) * dy;
            if (go && xx >= 0 && xx < GRID_N && yy >= 0 && yy < GRID_N &&
                board_q[yy[2:0]][xx[2:0]] == mark)
               run_len = run_len + 1;
            else
               go = 1'b0;
         end
      end
      hit = (run_len >= WIN_LEN);
   end

   always_comb begin
      state_d    = state_q;
      do_restart = 1'b0;
      do_place   = 1'b0;
      do_move    = 1'b0;
      check_last = 1'b0;
      case (state_q)
         S_PLAY: begin
            if (press[5]) begin
               do_restart = 1'b1;
            end else if (press[4]) begin
               if (cur_cell == 2'b00) begin
                  do_place = 1'b1;
                  state_d  = S_CHECK;
               end
            end else if (|press[3:0]) begin
               do_move = 1'b1;
            end
         end
         S_CHECK: begin
            if (press[5]) begin
               do_restart = 1'b1;
               state_d    = S_PLAY;
            end else if (dir_q == 2'd3) begin
               check_last = 1'b1;
               state_d    = (win_q || hit || move_count == CELLS) ? S_OVER : S_PLAY;
            end
         end
         S_OVER: begin
            if (press[5]) begin
               do_restart = 1'b1;
               state_d    = S_PLAY;
            end
         end
         default: state_d = S_PLAY;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state_q <= S_PLAY;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_q <= '0;
         // NOTE: the board is a small register file that must read empty after reset, so it is reset explicitly.
         for (int r = 0; r < GRID_N; r++)
            for (int c = 0; c < GRID_N; c++)
               board_q[r][c] <= 2'b00;
         cursor_x   <= '0;
         cursor_y   <= '0;
         turn       <= 1'b0;
         winner     <= 2'b00;
         move_count <= '0;
         px_q       <= '0;
         py_q       <= '0;
         player_q   <= 1'b0;
         dir_q      <= '0;
         win_q      <= 1'b0;
      end else begin
         btn_q <= btn_now;
         if (do_restart) begin
            for (int r = 0; r < GRID_N; r++)
               for (int c = 0; c < GRID_N; c++)
                  board_q[r][c] <= 2'b00;
            cursor_x   <= '0;
            cursor_y   <= '0;
            turn       <= 1'b0;
            winner     <= 2'b00;
            move_count <= '0;
            dir_q      <= '0;
            win_q      <= 1'b0;
         end else begin
            if (do_place) begin
               board_q[cursor_y][cursor_x] <= turn ? 2'b10 : 2'b01;
               px_q       <= cursor_x;
               py_q       <= cursor_y;
               player_q   <= turn;
               move_count <= move_count + 7'd1;
               dir_q      <= '0;
               win_q      <= 1'b0;
            end
            if (do_move) begin
               if (press[3])
                  cursor_y <= (cursor_y == 3'd0) ? ((WRAP != 0) ? MAX_C : 3'd0) : cursor_y - 3'd1;
               else if (press[2])
                  cursor_y <= (cursor_y == MAX_C) ? ((WRAP != 0) ? 3'd0 : MAX_C) : cursor_y + 3'd1;
               else if (press[1])
                  cursor_x <= (cursor_x == 3'd0) ? ((WRAP != 0) ? MAX_C : 3'd0) : cursor_x - 3'd1;
               else
                  cursor_x <= (cursor_x == MAX_C) ? ((WRAP != 0) ? 3'd0 : MAX_C) : cursor_x + 3'd1;
            end
            if (state_q == S_CHECK) begin
               dir_q <= dir_q + 2'd1;
               if (hit) win_q <= 1'b1;
               if (check_last) begin
                  if (win_q || hit)
                     winner <= player_q ? 2'b10 : 2'b01;
                  else if (move_count != CELLS)
                     turn <= ~turn;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_board_game_core.sv
// Bench for board_game_core: a 3x3/K3/wrap instance and a 5x5/K4/saturate instance
// share one stimulus port; each move result is scoreboarded when busy drops.
module tb_board_game_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       sel;
   logic [5:0] btns;                  // {start, a, up, down, left, right}
   logic [2:0] rd_x, rd_y;
   logic [5:0] b3, b5;

   logic [1:0] rd_cell3, rd_cell5, win3, win5;
   logic [2:0] cx3, cy3, cx5, cy5;
   logic       turn3, turn5, busy3, busy5, over3, over5;
   logic [6:0] mc3, mc5;

   assign b3 = sel ? 6'd0 : btns;
   assign b5 = sel ? btns : 6'd0;

   board_game_core #(.GRID_N(3), .WIN_LEN(3), .WRAP(1)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .btn_up(b3[3]), .btn_down(b3[2]), .btn_left(b3[1]), .btn_right(b3[0]),
      .btn_a(b3[4]), .btn_start(b3[5]),
      .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell3),
      .cursor_x(cx3), .cursor_y(cy3), .turn(turn3), .busy(busy3),
      .game_over(over3), .winner(win3), .move_count(mc3)
   );

   board_game_core #(.GRID_N(5), .WIN_LEN(4), .WRAP(0)) dut5 (
      .clk(clk), .rst_n(rst_n),
      .btn_up(b5[3]), .btn_down(b5[2]), .btn_left(b5[1]), .btn_right(b5[0]),
      .btn_a(b5[4]), .btn_start(b5[5]),
      .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell5),
      .cursor_x(cx5), .cursor_y(cy5), .turn(turn5), .busy(busy5),
      .game_over(over5), .winner(win5), .move_count(mc5)
   );

   logic [1:0] rd_cell_s, win_s;
   logic [2:0] cx_s, cy_s;
   logic       turn_s, busy_s, over_s;
   logic [6:0] mc_s;
   assign rd_cell_s = sel ? rd_cell5 : rd_cell3;
   assign win_s     = sel ? win5  : win3;
   assign cx_s      = sel ? cx5   : cx3;
   assign cy_s      = sel ? cy5   : cy3;
   assign turn_s    = sel ? turn5 : turn3;
   assign busy_s    = sel ? busy5 : busy3;
   assign over_s    = sel ? over5 : over3;
   assign mc_s      = sel ? mc5   : mc3;

   localparam logic [5:0] B_START = 6'b100000;
   localparam logic [5:0] B_A     = 6'b010000;
   localparam logic [5:0] B_UP    = 6'b001000;
   localparam logic [5:0] B_DOWN  = 6'b000100;
   localparam logic [5:0] B_LEFT  = 6'b000010;
   localparam logic [5:0] B_RIGHT = 6'b000001;

   typedef struct {
      int busy_len;
      int over;
      int winner;
      int turn;
      int moves;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cur_x = 0, cur_y = 0, exp_turn = 0, exp_moves = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: a result is presented when busy falls; compare it with the oldest expectation.
   initial begin
      exp_t e;
      int   busy_cnt;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (busy_s === 1'b1) begin
            busy_cnt++;
         end else if (busy_cnt != 0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: busy for %0d cycles with nothing expected", busy_cnt);
            end else begin
               e = exp_q.pop_front();
               check("sb_busy_len",  busy_cnt, e.busy_len);
               check("sb_game_over", over_s,   e.over);
               check("sb_winner",    win_s,    e.winner);
               check("sb_turn",      turn_s,   e.turn);
               check("sb_moves",     mc_s,     e.moves);
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic tap(input logic [5:0] m);
      btns = m;
      @(negedge clk);
      btns = '0;
      @(negedge clk);
   endtask

   task automatic goto_cell(input int x, input int y);
      while (cur_x < x) begin tap(B_RIGHT); cur_x++; end
      while (cur_x > x) begin tap(B_LEFT);  cur_x--; end
      while (cur_y < y) begin tap(B_DOWN);  cur_y++; end
      while (cur_y > y) begin tap(B_UP);    cur_y--; end
   endtask

   task automatic place(input int x, input int y, input int win_code, input int ends);
      goto_cell(x, y);
      exp_moves++;
      if (ends == 0) exp_turn = 1 - exp_turn;
      exp_q.push_back('{4, ends, win_code, exp_turn, exp_moves});
      tap(B_A);
      repeat (4) @(negedge clk);
   endtask

   task automatic rd_check(input int x, input int y, input logic [1:0] e);
      rd_x = 3'(x);
      rd_y = 3'(y);
      #1;
      check($sformatf("rd_cell(%0d,%0d)", x, y), rd_cell_s, e);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_cursor_x"},   cx_s,   0);
      check({tag, "_cursor_y"},   cy_s,   0);
      check({tag, "_turn"},       turn_s, 0);
      check({tag, "_busy"},       busy_s, 0);
      check({tag, "_game_over"},  over_s, 0);
      check({tag, "_winner"},     win_s,  0);
      check({tag, "_move_count"}, mc_s,   0);
   endtask

   task automatic model_restart();
      cur_x = 0; cur_y = 0; exp_turn = 0; exp_moves = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      sel   = 1'b0;
      btns  = '0;
      rd_x  = '0;
      rd_y  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("reset3");
      rd_check(0, 0, 2'b00);
      sel = 1'b1; #1;
      check_idle("reset5");
      sel = 1'b0; #1;

      // Wrapping cursor and level-held buttons.
      tap(B_LEFT);  cur_x = 2;
      check("wrap_left_x", cx_s, 2);
      tap(B_UP);    cur_y = 2;
      check("wrap_up_y", cy_s, 2);
      tap(B_DOWN);  cur_y = 0;
      check("wrap_down_y", cy_s, 0);
      btns = B_LEFT;
      repeat (100) @(negedge clk);
      btns = '0;
      @(negedge clk);
      cur_x = 1;
      check("hold_left_x", cx_s, 1);

      // Diagonal X win, with an occupied-cell press and a simultaneous a+right.
      place(0, 0, 0, 0);
      place(0, 1, 0, 0);
      place(1, 1, 0, 0);
      tap(B_A);
      check("occupied_busy", busy_s, 0);
      check("occupied_turn", turn_s, 1);
      check("occupied_moves", mc_s, 3);
      rd_check(1, 1, 2'b01);
      goto_cell(0, 2);
      exp_moves++;
      exp_turn = 1 - exp_turn;
      exp_q.push_back('{4, 0, 0, exp_turn, exp_moves});
      tap(B_A | B_RIGHT);
      repeat (4) @(negedge clk);
      check("a_right_cursor_x", cx_s, 0);
      rd_check(0, 2, 2'b10);
      place(2, 2, 1, 1);
      check("win_game_over", over_s, 1);
      check("win_winner", win_s, 1);
      check("win_moves", mc_s, 5);
      rd_check(2, 2, 2'b01);
      rd_check(3, 0, 2'b00);
      tap(B_UP);
      check("over_cursor_frozen", cy_s, 2);
      tap(B_A);
      check("over_a_ignored", mc_s, 5);

      // Reset held for one cycle while in OVER.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_idle("over_reset");
      rd_check(2, 2, 2'b00);
      rd_check(0, 0, 2'b00);
      model_restart();

      // Draw: X O X / X O O / O X X.
      place(0, 0, 0, 0);
      place(1, 0, 0, 0);
      place(2, 0, 0, 0);
      place(1, 1, 0, 0);
      place(0, 1, 0, 0);
      place(2, 1, 0, 0);
      place(1, 2, 0, 0);
      place(0, 2, 0, 0);
      place(2, 2, 0, 1);
      check("draw_game_over", over_s, 1);
      check("draw_winner", win_s, 0);
      check("draw_moves", mc_s, 9);
      tap(B_START);
      model_restart();
      check_idle("draw_restart");
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 3; x++)
            rd_check(x, y, 2'b00);

      // Start lands in the second CHECK cycle and aborts the check.
      goto_cell(1, 1);
      exp_q.push_back('{2, 0, 0, 0, 0});
      btns = B_A;
      @(negedge clk);
      btns = '0;
      @(negedge clk);
      btns = B_START;
      @(negedge clk);
      btns = '0;
      @(negedge clk);
      model_restart();
      check_idle("abort");
      rd_check(1, 1, 2'b00);

      // 5x5, K=4, saturating cursor.
      sel = 1'b1; #1;
      goto_cell(4, 4);
      tap(B_RIGHT);
      tap(B_DOWN);
      check("sat_cursor_x", cx_s, 4);
      check("sat_cursor_y", cy_s, 4);
      place(3, 0, 0, 0);
      place(4, 4, 0, 0);
      place(2, 1, 0, 0);
      place(4, 3, 0, 0);
      place(1, 2, 0, 0);
      place(4, 2, 0, 0);
      place(0, 3, 1, 1);
      check("anti_game_over", over_s, 1);
      check("anti_winner", win_s, 1);
      check("anti_moves", mc_s, 7);
      rd_check(0, 3, 2'b01);
      rd_check(4, 2, 2'b10);
      rd_check(5, 0, 2'b00);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
